// File: rtl/mul_pkg.sv
// Shared definitions for the iterative significand multiplier: FSM encoding,
// exponent bias and the radix-4 iteration count.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    function automatic int mul_bias(input int expo_w);
        return (32'sd1 <<< (expo_w - 32'sd1)) - 32'sd1;
    endfunction

    // ceil((mant_w+1)/2): two multiplier bits retired per cycle
    function automatic int mul_iters(input int mant_w);
        return (mant_w + 32'sd2) / 32'sd2;
    endfunction

    localparam int MUL_ITERS_FP32 = mul_iters(23);

endpackage

// File: rtl/mul_radix4_step.sv
// One radix-4 shift-add step: adds multiplicand times a 2-bit digit to the
// running accumulator.
module mul_radix4_step #(
    parameter int ACC_W = 50
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [1:0]       mbits_i,
    input  logic [ACC_W-1:0] mcand_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] pp_s;

    // Partial product for the current multiplier digit.
    always_comb begin
        pp_s = {ACC_W{1'b0}};
        case (mbits_i)
            2'd0:    pp_s = {ACC_W{1'b0}};
            2'd1:    pp_s = mcand_i;
            2'd2:    pp_s = {mcand_i[ACC_W-2:0], 1'b0};
            2'd3:    pp_s = mcand_i + {mcand_i[ACC_W-2:0], 1'b0};
            default: pp_s = {ACC_W{1'b0}};
        endcase
        acc_o = acc_i + pp_s;
    end

endmodule

// File: rtl/mul_pipe2.sv
// Multiply stage of a floating-point multiplier: captures classified operands,
// forms the unbiased exponent sum and sign, and builds the full significand
// product with an iterative radix-4 shift-add (special operands skip it).
module mul_pipe2
    import mul_pkg::*;
#(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SIGN_W-1:0]         a_sign,
    input  logic [SIGN_W-1:0]         b_sign,
    input  logic [EXPO_W-1:0]         a_expo,
    input  logic [EXPO_W-1:0]         b_expo,
    input  logic [MANT_W-1:0]         a_mant,
    input  logic [MANT_W-1:0]         b_mant,
    input  logic                      a_is_nor,
    input  logic                      b_is_nor,
    input  logic                      a_is_sub,
    input  logic                      b_is_sub,
    input  logic                      r_isnan,
    input  logic                      is_inf_nan,
    input  logic                      r_is0nan,
    input  logic                      status_nv,
    input  logic [1:0]                rnd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SIGN_W-1:0]         r_sign,
    output logic [EXPO_W+1:0]         r_expo,
    output logic [2*(MANT_W+1)-1:0]   r_prod,
    output logic                      r_isnan_o,
    output logic                      is_inf_nan_o,
    output logic                      r_is0nan_o,
    output logic                      status_nv_o,
    output logic [1:0]                rnd_out
);

    localparam int SIG_W  = MANT_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int ACC_W  = PROD_W + 2;
    localparam int XW     = EXPO_W + 2;
    localparam int BIAS   = mul_bias(EXPO_W);
    localparam int ITERS  = mul_iters(MANT_W);
    localparam int CNT_W  = $clog2(ITERS + 1);

    mul_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [ACC_W-1:0]    mcand_q;
    logic [SIG_W-1:0]    mplier_q;
    logic [SIGN_W-1:0]   r_sign_q;
    logic [XW-1:0]       r_expo_q;
    logic [PROD_W-1:0]   r_prod_q;
    logic                r_isnan_q;
    logic                is_inf_nan_q;
    logic                r_is0nan_q;
    logic                status_nv_q;
    logic [1:0]          rnd_q;

    logic                accept_s;
    logic                special_s;
    logic                last_iter_s;
    logic [EXPO_W-1:0]   eff_a_s;
    logic [EXPO_W-1:0]   eff_b_s;
    logic [XW-1:0]       expo_d;
    logic [SIG_W-1:0]    sig_a_s;
    logic [SIG_W-1:0]    sig_b_s;

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign accept_s    = in_valid && in_ready;
    assign special_s   = is_inf_nan || r_is0nan;
    assign last_iter_s = (cnt_q == CNT_W'(ITERS - 1));

    // Subnormals use exponent 1 so the significand's missing hidden bit is compensated.
    assign eff_a_s = a_is_sub ? {{(EXPO_W-1){1'b0}}, 1'b1} : a_expo;
    assign eff_b_s = b_is_sub ? {{(EXPO_W-1){1'b0}}, 1'b1} : b_expo;
    assign expo_d  = {2'b00, eff_a_s} + {2'b00, eff_b_s} - XW'(BIAS);
    assign sig_a_s = {a_is_nor, a_mant};
    assign sig_b_s = {b_is_nor, b_mant};

    mul_radix4_step #(
        .ACC_W (ACC_W)
    ) u_step (
        .acc_i   (acc_q),
        .mbits_i (mplier_q[1:0]),
        .mcand_i (mcand_q),
        .acc_o   (acc_d)
    );

    // Control FSM and all datapath/result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            acc_q        <= {ACC_W{1'b0}};
            mcand_q      <= {ACC_W{1'b0}};
            mplier_q     <= {SIG_W{1'b0}};
            r_sign_q     <= {SIGN_W{1'b0}};
            r_expo_q     <= {XW{1'b0}};
            r_prod_q     <= {PROD_W{1'b0}};
            r_isnan_q    <= 1'b0;
            is_inf_nan_q <= 1'b0;
            r_is0nan_q   <= 1'b0;
            status_nv_q  <= 1'b0;
            rnd_q        <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        r_sign_q     <= a_sign ^ b_sign;
                        r_expo_q     <= expo_d;
                        r_prod_q     <= {PROD_W{1'b0}};
                        r_isnan_q    <= r_isnan;
                        is_inf_nan_q <= is_inf_nan;
                        r_is0nan_q   <= r_is0nan;
                        status_nv_q  <= status_nv;
                        rnd_q        <= rnd;
                        cnt_q        <= {CNT_W{1'b0}};
                        acc_q        <= {ACC_W{1'b0}};
                        mcand_q      <= {{(ACC_W-SIG_W){1'b0}}, sig_a_s};
                        mplier_q     <= sig_b_s;
                        state_q      <= special_s ? ST_DONE : ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= {mcand_q[ACC_W-3:0], 2'b00};
                    mplier_q <= {2'b00, mplier_q[SIG_W-1:2]};
                    cnt_q    <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_iter_s) begin
                        r_prod_q <= acc_d[PROD_W-1:0];
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign r_sign       = r_sign_q;
    assign r_expo       = r_expo_q;
    assign r_prod       = r_prod_q;
    assign r_isnan_o    = r_isnan_q;
    assign is_inf_nan_o = is_inf_nan_q;
    assign r_is0nan_o   = r_is0nan_q;
    assign status_nv_o  = status_nv_q;
    assign rnd_out      = rnd_q;

endmodule

// File: tb/tb_mul_pipe2.sv
// Directed bench for mul_pipe2: fp32 operand pairs with hand-computed products,
// latency, back-pressure hold, drain timing and mid-operation reset.
module tb_mul_pipe2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        a_sign, b_sign;
    logic [7:0]  a_expo, b_expo;
    logic [22:0] a_mant, b_mant;
    logic        a_is_nor, b_is_nor, a_is_sub, b_is_sub;
    logic        r_isnan, is_inf_nan, r_is0nan, status_nv;
    logic [1:0]  rnd;
    logic        out_valid;
    logic        out_ready;
    logic        r_sign;
    logic [9:0]  r_expo;
    logic [47:0] r_prod;
    logic        r_isnan_o, is_inf_nan_o, r_is0nan_o, status_nv_o;
    logic [1:0]  rnd_out;

    int n_tests = 0;
    int n_fail  = 0;

    mul_pipe2 #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_sign       (a_sign),
        .b_sign       (b_sign),
        .a_expo       (a_expo),
        .b_expo       (b_expo),
        .a_mant       (a_mant),
        .b_mant       (b_mant),
        .a_is_nor     (a_is_nor),
        .b_is_nor     (b_is_nor),
        .a_is_sub     (a_is_sub),
        .b_is_sub     (b_is_sub),
        .r_isnan      (r_isnan),
        .is_inf_nan   (is_inf_nan),
        .r_is0nan     (r_is0nan),
        .status_nv    (status_nv),
        .rnd          (rnd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .r_sign       (r_sign),
        .r_expo       (r_expo),
        .r_prod       (r_prod),
        .r_isnan_o    (r_isnan_o),
        .is_inf_nan_o (is_inf_nan_o),
        .r_is0nan_o   (r_is0nan_o),
        .status_nv_o  (status_nv_o),
        .rnd_out      (rnd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        a_sign     = a[31];
        a_expo     = a[30:23];
        a_mant     = a[22:0];
        a_is_nor   = (a[30:23] != 8'h00) && (a[30:23] != 8'hFF);
        a_is_sub   = (a[30:23] == 8'h00) && (a[22:0] != 23'd0);
        b_sign     = b[31];
        b_expo     = b[30:23];
        b_mant     = b[22:0];
        b_is_nor   = (b[30:23] != 8'h00) && (b[30:23] != 8'hFF);
        b_is_sub   = (b[30:23] == 8'h00) && (b[22:0] != 23'd0);
        r_isnan    = 1'b0;
        is_inf_nan = 1'b0;
        r_is0nan   = 1'b0;
        status_nv  = 1'b0;
        rnd        = rm;
    endtask

    // Present in_valid from a negedge, accept on the next posedge.
    task automatic accept_op();
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called just after the accept edge; lat counts that edge as cycle 1.
    task automatic wait_result(input string tag, input int exp_lat);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        chk({tag, "_seen"}, {63'd0, seen}, 64'd1);
        chk({tag, "_lat"}, 64'(n + 1), 64'(exp_lat));
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_drain_in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_drain_out_valid"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        bit early;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_ops(32'h0, 32'h0, 2'b00);

        // Reset state
        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_r_prod", {16'd0, r_prod}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // 1.0 * 1.0
        set_ops(32'h3F800000, 32'h3F800000, 2'b00);
        accept_op();
        @(negedge clk);
        chk("one_busy_in_ready", {63'd0, in_ready}, 64'd0);
        wait_result("one", 12);
        chk("one_prod", {16'd0, r_prod}, 64'h0000_4000_0000_0000);
        chk("one_expo", {54'd0, r_expo}, 64'd127);
        chk("one_sign", {63'd0, r_sign}, 64'd0);
        chk("one_nv", {63'd0, status_nv_o}, 64'd0);

        // Drain with a new operand pending: must not be accepted in the drain cycle
        set_ops(32'h00000001, 32'h3F800000, 2'b11);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("drain_no_accept_in_ready", {63'd0, in_ready}, 64'd1);
        chk("drain_no_accept_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        // subnormal * 1.0
        wait_result("sub", 13);
        chk("sub_prod", {16'd0, r_prod}, 64'h0000_0000_0080_0000);
        chk("sub_expo", {54'd0, r_expo}, 64'd1);
        chk("sub_rnd", {62'd0, rnd_out}, 64'd3);
        drain("sub");

        // -1.5 * -1.5 with back-pressure
        set_ops(32'hBFC00000, 32'hBFC00000, 2'b10);
        accept_op();
        wait_result("m15", 13);
        for (int k = 0; k < 5; k++) begin
            chk("m15_hold_prod", {16'd0, r_prod}, 64'h0000_9000_0000_0000);
            chk("m15_hold_expo", {54'd0, r_expo}, 64'd127);
            chk("m15_hold_sign", {63'd0, r_sign}, 64'd0);
            chk("m15_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("m15_hold_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        chk("m15_rnd", {62'd0, rnd_out}, 64'd2);
        drain("m15");

        // -inf * 0 special path
        set_ops(32'hFF800000, 32'h00000000, 2'b01);
        r_isnan    = 1'b1;
        is_inf_nan = 1'b1;
        r_is0nan   = 1'b1;
        status_nv  = 1'b1;
        accept_op();
        set_ops(32'h0, 32'h0, 2'b00);
        wait_result("inf0", 1);
        chk("inf0_prod", {16'd0, r_prod}, 64'd0);
        chk("inf0_expo", {54'd0, r_expo}, 64'd128);
        chk("inf0_sign", {63'd0, r_sign}, 64'd1);
        chk("inf0_nv", {63'd0, status_nv_o}, 64'd1);
        chk("inf0_isnan", {63'd0, r_isnan_o}, 64'd1);
        chk("inf0_infnan", {63'd0, is_inf_nan_o}, 64'd1);
        chk("inf0_0nan", {63'd0, r_is0nan_o}, 64'd1);
        chk("inf0_rnd", {62'd0, rnd_out}, 64'd1);
        drain("inf0");

        // Reset in the middle of the iterative multiply
        set_ops(32'h3F800000, 32'h3F800000, 2'b10);
        accept_op();
        set_ops(32'h0, 32'h0, 2'b00);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_expo", {54'd0, r_expo}, 64'd0);
        chk("midrst_rnd", {62'd0, rnd_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        early = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) early = 1'b1;
        end
        chk("midrst_no_valid", {63'd0, early}, 64'd0);

        // Next operand after reset
        set_ops(32'hBFC00000, 32'hBFC00000, 2'b00);
        accept_op();
        wait_result("after_rst", 13);
        chk("after_rst_prod", {16'd0, r_prod}, 64'h0000_9000_0000_0000);
        chk("after_rst_expo", {54'd0, r_expo}, 64'd127);
        drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_pipe2.md
MUL_PIPE2 -- requirements
Module: mul_pipe2

Interface
REQ-001 Parameters SHALL be: SIGN_W, 1, sign width; EXPO_W, 8, exponent width; MANT_W, 23, stored mantissa width.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  upstream stage-1 fields valid.
REQ-005 in_ready  out  1  stage accepts a new operand set.
REQ-006 a_sign, b_sign  in  1  operand signs.
REQ-007 a_expo, b_expo  in  EXPO_W  biased exponents.
REQ-008 a_mant, b_mant  in  MANT_W  stored mantissas.
REQ-009 a_is_nor, b_is_nor, a_is_sub, b_is_sub  in  1  operand class flags.
REQ-010 r_isnan, is_inf_nan, r_is0nan, status_nv  in  1  special-case flags.
REQ-011 rnd  in  2  rounding mode.
REQ-012 out_valid  out  1  result fields valid; out_ready  in  1  downstream accepts.
REQ-013 r_sign  out  1  product sign; r_expo  out  EXPO_W+2  signed unbiased-adjusted exponent.
REQ-014 r_prod  out  2*(MANT_W+1)  significand product.
REQ-015 r_isnan_o, is_inf_nan_o, r_is0nan_o, status_nv_o  out  1  registered flags; rnd_out  out  2  registered rounding mode.

Function
REQ-016 FSM states SHALL be IDLE, MUL, DONE; in_ready = (state==IDLE).
REQ-017 Accept SHALL occur on in_valid && in_ready; all inputs captured that edge.
REQ-018 Significands SHALL be {a_is_nor,a_mant} and {b_is_nor,b_mant} (MANT_W+1 bits).
REQ-019 Effective exponent SHALL be 1 when is_sub, else expo; r_expo = effA + effB - (2^(EXPO_W-1)-1), signed EXPO_W+2 bits, computed at accept.
REQ-020 r_sign SHALL be a_sign XOR b_sign.
REQ-021 Normal path: IDLE->MUL; radix-4 shift-add, 2 multiplier bits per cycle, ceil((MANT_W+1)/2) cycles (12 for fp32), then DONE.
REQ-022 Special path: is_inf_nan or r_is0nan at accept SHALL go IDLE->DONE directly with r_prod=0.
REQ-023 out_valid SHALL be (state==DONE); latency accept->out_valid: 13 cycles normal, 1 cycle special (fp32).
REQ-024 In DONE, all outputs SHALL hold stable until out_ready; on out_valid && out_ready go IDLE.
REQ-025 No new accept in the cycle a result is drained; next accept earliest the following cycle.
REQ-026 in_valid while busy SHALL be ignored (upstream holds).
REQ-027 Partial-product accumulator SHALL be 2*(MANT_W+1)+2 bits; no overflow truncation before final r_prod.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, all outputs and internal registers 0; in_ready reads 1 after release.
REQ-029 Reset mid-MUL or mid-DONE SHALL abandon the operation; no out_valid pulse after release.

Structure
REQ-030 Shared package mul_pkg SHALL hold the FSM state enum, bias function of EXPO_W, and iteration-count constant.
REQ-031 One sub-module mul_radix4_step (combinational: accumulator, 2 multiplier bits, multiplicand -> next accumulator) SHALL be instantiated once.

Verification
REQ-032 a=b=0x3F800000 (1.0) -> r_prod=0x400000000000, r_expo=127, r_sign=0, out_valid 13 cycles after accept.
REQ-033 a=b=0xBFC00000 (-1.5) -> r_prod=0x900000000000, r_expo=127, r_sign=0.
REQ-034 a=0x00000001 (subnormal), b=0x3F800000 -> r_prod=0x000000800000, r_expo=1.
REQ-035 inf*0 with is_inf_nan=1, r_is0nan=1, status_nv=1 -> out_valid 1 cycle after accept, r_prod=0, status_nv_o=1.
REQ-036 out_ready held low 5 cycles in DONE -> outputs unchanged, in_ready=0; then drain, in_ready=1 next cycle.
REQ-037 rst_n asserted at MUL cycle 6 -> immediate state IDLE, outputs 0, no out_valid after release; next operand completes correctly.
